hilo_acc_unit: RTL

- Architectural HI/LO register pair sitting directly downstream of the EXE multiply/divide unit.
- Commits plain multiply/divide results and MTHI/MTLO writes.
- Performs MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO} through a 2-cycle split-carry adder.
- Exposes registered HI/LO to the MFHI/MFLO path and a busy/ready handshake so the pipeline stalls while an accumulate is in flight.

---
 rtl/hilo_acc_unit_if.sv | 32 +++
 rtl/hilo_acc_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/hilo_acc_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_acc_unit_if : request/response bundle between the EXE mul/div unit and HI/LO
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface hilo_acc_unit_if #(
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [DATA_W-1:0] req_hi;
   logic [DATA_W-1:0] req_lo;
   logic              flush;
   logic [DATA_W-1:0] hi_o;
   logic [DATA_W-1:0] lo_o;
   logic              busy;
   logic              acc_done;

   modport master (
      output req_valid, req_op, req_hi, req_lo, flush,
      input  req_ready, hi_o, lo_o, busy, acc_done
   );

   modport slave (
      input  req_valid, req_op, req_hi, req_lo, flush,
      output req_ready, hi_o, lo_o, busy, acc_done
   );
endinterface

`default_nettype wire

// File: rtl/hilo_acc_unit.sv
// -----------------------------------------------------------------------------
// hilo_acc_unit : architectural HI/LO pair with 2-cycle split-carry MADD/MSUB
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module hilo_acc_unit #(
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   hilo_acc_unit_if.slave   bus
);
   localparam logic [2:0] OP_WR_BOTH = 3'b000;
   localparam logic [2:0] OP_ACC_ADD = 3'b001;
   localparam logic [2:0] OP_ACC_SUB = 3'b010;
   localparam logic [2:0] OP_MTHI    = 3'b011;
   localparam logic [2:0] OP_MTLO    = 3'b100;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] hi, hi_nxt;
   logic [DATA_W-1:0] lo, lo_nxt;
   logic [DATA_W-1:0] hi_opnd, hi_opnd_nxt;
   logic [DATA_W:0]   lo_sum, lo_sum_nxt;
   logic              acc_done, acc_done_nxt;
   logic              accept;
   logic              is_sub;
   logic [DATA_W-1:0] lo_opnd;

   assign accept  = bus.req_valid && (state == IDLE) && !bus.flush;
   assign is_sub  = (bus.req_op == OP_ACC_SUB);
   // Subtraction is two's complement: invert the operand, inject carry-in on the low word
   assign lo_opnd = is_sub ? ~bus.req_lo : bus.req_lo;

   always_comb begin
      state_nxt    = state;
      hi_nxt       = hi;
      lo_nxt       = lo;
      hi_opnd_nxt  = hi_opnd;
      lo_sum_nxt   = lo_sum;
      acc_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (bus.req_op)
                  OP_WR_BOTH: begin
                     hi_nxt = bus.req_hi;
                     lo_nxt = bus.req_lo;
                  end
                  OP_ACC_ADD, OP_ACC_SUB: begin
                     lo_sum_nxt  = {1'b0, lo} + {1'b0, lo_opnd} + {{DATA_W{1'b0}}, is_sub};
                     hi_opnd_nxt = is_sub ? ~bus.req_hi : bus.req_hi;
                     state_nxt   = ACC;
                  end
                  OP_MTHI: hi_nxt = bus.req_hi;
                  OP_MTLO: lo_nxt = bus.req_lo;
                  default: ;
               endcase
            end
         end
         ACC: begin
            state_nxt = IDLE;
            if (!bus.flush) begin
               hi_nxt       = hi + hi_opnd + {{(DATA_W-1){1'b0}}, lo_sum[DATA_W]};
               lo_nxt       = lo_sum[DATA_W-1:0];
               acc_done_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         hi       <= '0;
         lo       <= '0;
         hi_opnd  <= '0;
         lo_sum   <= '0;
         acc_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         hi       <= hi_nxt;
         lo       <= lo_nxt;
         hi_opnd  <= hi_opnd_nxt;
         lo_sum   <= lo_sum_nxt;
         acc_done <= acc_done_nxt;
      end
   end

   assign bus.hi_o      = hi;
   assign bus.lo_o      = lo;
   assign bus.busy      = (state == ACC);
   assign bus.req_ready = (state == IDLE);
   assign bus.acc_done  = acc_done;
endmodule

`default_nettype wire
